// File: rtl/angle_servo_ctrl_if.sv
// angle_servo_ctrl_if
//   Bundles the command, encoder and PWM-handshake signals of angle_servo_ctrl.
//   slave  : view used by angle_servo_ctrl (commands/encoder/PWM status in, PWM request/status out)
//   master : view used by the surrounding subsystem (register block, encoder reader, PWM generator)
//   Signals:
//     target_angle/angle_update/abort_angle/cruise_power : motion commands
//     enc_angle/enc_valid                                 : encoder samples
//     pwm_enable/pwm_done                                 : PWM generator status
//     pwm_ratio/pwm_direction/pwm_update                  : PWM request
//     current_angle/angle_done/startup_fail/busy          : controller status
interface angle_servo_ctrl_if #(
  parameter int unsigned ANGLE_W = 12,
  parameter int unsigned PWM_W   = 8
);
  logic [ANGLE_W-1:0] target_angle;
  logic               angle_update;
  logic               abort_angle;
  logic [PWM_W-1:0]   cruise_power;
  logic [ANGLE_W-1:0] enc_angle;
  logic               enc_valid;
  logic               pwm_enable;
  logic               pwm_done;
  logic [PWM_W-1:0]   pwm_ratio;
  logic               pwm_direction;
  logic               pwm_update;
  logic [ANGLE_W-1:0] current_angle;
  logic               angle_done;
  logic               startup_fail;
  logic               busy;

  modport slave (
    input  target_angle, angle_update, abort_angle, cruise_power,
           enc_angle, enc_valid, pwm_enable, pwm_done,
    output pwm_ratio, pwm_direction, pwm_update,
           current_angle, angle_done, startup_fail, busy
  );

  modport master (
    output target_angle, angle_update, abort_angle, cruise_power,
           enc_angle, enc_valid, pwm_enable, pwm_done,
    input  pwm_ratio, pwm_direction, pwm_update,
           current_angle, angle_done, startup_fail, busy
  );
endinterface

// File: rtl/angle_servo_ctrl.sv
// angle_servo_ctrl
//   Closed-loop steering controller for one swerve-module rotation motor. Drives
//   the motor toward a target angle using sampled encoder angles, with ramped
//   power, shortest-path direction, deadband completion and stall detection.
//   Optional feature macro: ANGLE_SERVO_SLOWDOWN_EN (enables the DECEL ramp-down
//   when the remaining error falls inside SLOW_ZONE).
// Ports:
//   clock   : main clock
//   reset_n : asynchronous active-low reset
//   bus     : angle_servo_ctrl_if.slave
//             in : target_angle, angle_update, abort_angle, cruise_power,
//                  enc_angle, enc_valid, pwm_enable, pwm_done
//             out: pwm_ratio, pwm_direction, pwm_update, current_angle,
//                  angle_done, startup_fail, busy
module angle_servo_ctrl #(
  parameter int unsigned ANGLE_W      = 12,
  parameter int unsigned PWM_W        = 8,
  parameter int unsigned DEADBAND     = 4,
  parameter int unsigned SLOW_ZONE    = 128,
  parameter int unsigned RAMP_STEP    = 4,
  parameter int unsigned MIN_POWER    = 24,
  parameter int unsigned STALL_CYCLES = 500000
) (
  input  logic               clock,
  input  logic               reset_n,
  angle_servo_ctrl_if.slave  bus
);

  localparam int unsigned STALL_W = $clog2(STALL_CYCLES + 1);
  localparam int unsigned PW1     = PWM_W + 1;

  localparam logic [ANGLE_W-1:0] HALF_TURN = {1'b1, {(ANGLE_W-1){1'b0}}};
  localparam logic [ANGLE_W-1:0] DB        = ANGLE_W'(DEADBAND);
  localparam logic [ANGLE_W-1:0] SZ        = ANGLE_W'(SLOW_ZONE);
  localparam logic [PWM_W-1:0]   MINP      = PWM_W'(MIN_POWER);
  localparam logic [PWM_W-1:0]   STEP_N    = PWM_W'(RAMP_STEP);
  localparam logic [PW1-1:0]     STEP_W    = PW1'(RAMP_STEP);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEL,
    S_CRUISE,
    S_DECEL,
    S_DONE,
    S_FAULT
  } state_t;

  state_t             state_q, state_d;
  logic [ANGLE_W-1:0] target_q, target_d;
  logic [ANGLE_W-1:0] current_q;
  logic [PWM_W-1:0]   ratio_q, ratio_d;
  logic               dir_q, dir_d;
  logic               upd_q, upd_d;
  logic               pending_q, pending_d;
  logic               done_q, done_d;
  logic               fail_q, fail_d;
  logic               sample_q;
  logic [STALL_W-1:0] stall_q;
  logic               stall_clr;
  logic               eval_hit;
  logic               moving;

  logic [ANGLE_W:0]   err_cur, err_new;
  logic               dir_cur, dir_new;
  logic [ANGLE_W-1:0] mag_cur, mag_new;
  logic [PWM_W-1:0]   ceiling;
  logic [PW1-1:0]     up_sum;

  // Returns {direction, magnitude} of the shortest rotation from cur to tgt.
  // Unsigned modular difference avoids any signed overflow; half-turn ties go up.
  function automatic logic [ANGLE_W:0] shortest_path(input logic [ANGLE_W-1:0] tgt,
                                                     input logic [ANGLE_W-1:0] cur);
    logic [ANGLE_W-1:0] d;
    d = tgt - cur;
    if (d <= HALF_TURN) shortest_path = {1'b1, d};
    else                shortest_path = {1'b0, (~d) + 1'b1};
  endfunction

  assign moving  = (state_q == S_ACCEL) || (state_q == S_CRUISE) || (state_q == S_DECEL);
  assign err_cur = shortest_path(target_q, current_q);
  assign err_new = shortest_path(bus.target_angle, current_q);
  assign dir_cur = err_cur[ANGLE_W];
  assign mag_cur = err_cur[ANGLE_W-1:0];
  assign dir_new = err_new[ANGLE_W];
  assign mag_new = err_new[ANGLE_W-1:0];
  assign ceiling = (bus.cruise_power < MINP) ? MINP : bus.cruise_power;
  assign up_sum  = {1'b0, ratio_q} + STEP_W;

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    ratio_d   = ratio_q;
    dir_d     = dir_q;
    upd_d     = 1'b0;
    done_d    = done_q;
    fail_d    = fail_q;
    stall_clr = 1'b0;
    eval_hit  = 1'b0;

    if (bus.abort_angle) begin
      // Forced zero: issued even with an update outstanding.
      state_d = S_IDLE;
      ratio_d = '0;
      fail_d  = 1'b0;
      upd_d   = (ratio_q != '0);
    end else if (state_q == S_FAULT) begin
      state_d = S_FAULT;
    end else if (moving && !bus.pwm_enable) begin
      state_d = S_IDLE;
      ratio_d = '0;
      upd_d   = 1'b1;
    end else if (moving && (stall_q == STALL_MAX)) begin
      state_d = S_FAULT;
      ratio_d = '0;
      upd_d   = 1'b1;
      fail_d  = 1'b1;
    end else if (!moving) begin
      if (bus.angle_update && bus.pwm_enable) begin
        target_d  = bus.target_angle;
        done_d    = 1'b0;
        stall_clr = 1'b1;
        if (mag_new <= DB) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          upd_d   = (ratio_q != '0);
          ratio_d = '0;
        end else begin
          state_d = S_ACCEL;
          ratio_d = MINP;
          dir_d   = dir_new;
          upd_d   = 1'b1;
        end
      end
    end else begin
      // Mid-motion retarget keeps the current ratio; the next encoder
      // evaluation picks up the new error and direction.
      if (bus.angle_update && bus.pwm_enable) begin
        target_d  = bus.target_angle;
        done_d    = 1'b0;
        stall_clr = 1'b1;
      end

      if (sample_q) begin
        if (mag_cur <= DB) begin
          state_d  = S_DONE;
          ratio_d  = '0;
          upd_d    = 1'b1;
          done_d   = 1'b1;
          eval_hit = 1'b1;
        end else if (dir_cur != dir_q) begin
          state_d  = S_ACCEL;
          ratio_d  = MINP;
          dir_d    = dir_cur;
          upd_d    = 1'b1;
          eval_hit = 1'b1;
        end
`ifdef ANGLE_SERVO_SLOWDOWN_EN
        else if ((state_q != S_DECEL) && (mag_cur <= SZ)) begin
          state_d = S_DECEL;
        end
`endif
      end

      // Ramp on the acknowledge of the outstanding update; with nothing
      // outstanding (quiet CRUISE just switched to DECEL) step right away.
      if (!eval_hit && (!pending_q || bus.pwm_done)) begin
        case (state_d)
          S_ACCEL: begin
            if (up_sum >= {1'b0, ceiling}) begin
              ratio_d = ceiling;
              state_d = S_CRUISE;
            end else begin
              ratio_d = up_sum[PWM_W-1:0];
            end
          end
          S_DECEL: begin
            if ({1'b0, ratio_q} >= ({1'b0, MINP} + STEP_W)) ratio_d = ratio_q - STEP_N;
            else                                            ratio_d = MINP;
          end
          default: ratio_d = ratio_q;
        endcase
        upd_d = (ratio_d != ratio_q);
      end
    end
  end

  always_comb begin
    pending_d = pending_q;
    if (upd_d)             pending_d = 1'b1;
    else if (bus.pwm_done) pending_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      target_q  <= '0;
      current_q <= '0;
      ratio_q   <= '0;
      dir_q     <= 1'b0;
      upd_q     <= 1'b0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
      sample_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      ratio_q   <= ratio_d;
      dir_q     <= dir_d;
      upd_q     <= upd_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
      sample_q  <= bus.enc_valid;
      if (bus.enc_valid) current_q <= bus.enc_angle;
    end
  end

  // Stall counter runs only while moving; any encoder movement restarts it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else if (!moving || stall_clr || (bus.enc_valid && (bus.enc_angle != current_q))) begin
      stall_q <= '0;
    end else if (stall_q != STALL_MAX) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign bus.pwm_ratio     = ratio_q;
  assign bus.pwm_direction = dir_q;
  assign bus.pwm_update    = upd_q;
  assign bus.current_angle = current_q;
  assign bus.angle_done    = done_q;
  assign bus.startup_fail  = fail_q;
  assign bus.busy          = moving;

endmodule

// File: tb/tb_angle_servo_ctrl.sv
// tb_angle_servo_ctrl
//   Directed self-checking bench for angle_servo_ctrl. Stall limit is shortened
//   to keep the run short; expectations for the DECEL ramp follow
//   ANGLE_SERVO_SLOWDOWN_EN.
module tb_angle_servo_ctrl;

  logic clock;
  logic reset_n;
  int   n_tests;
  int   n_fail;
  logic auto_done;
  int   cnt;
  int   exp_r;

  angle_servo_ctrl_if #(.ANGLE_W(12), .PWM_W(8)) bus();

  angle_servo_ctrl #(
    .ANGLE_W      (12),
    .PWM_W        (8),
    .DEADBAND     (4),
    .SLOW_ZONE    (128),
    .RAMP_STEP    (4),
    .MIN_POWER    (24),
    .STALL_CYCLES (200)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock; strobes drop after the edge, PWM generator acknowledges updates when auto_done.
  task automatic cyc();
    @(posedge clock);
    #1;
    bus.angle_update = 1'b0;
    bus.abort_angle  = 1'b0;
    bus.enc_valid    = 1'b0;
    bus.pwm_done     = auto_done && bus.pwm_update;
  endtask

  task automatic enc(input logic [11:0] a);
    bus.enc_angle = a;
    bus.enc_valid = 1'b1;
    cyc();
  endtask

  task automatic request(input logic [11:0] t);
    bus.target_angle = t;
    bus.angle_update = 1'b1;
    cyc();
  endtask

  task automatic abort_now();
    bus.abort_angle = 1'b1;
    cyc();
  endtask

  task automatic count_updates(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (bus.pwm_update) c++;
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    auto_done = 1'b1;
    reset_n = 1'b0;
    bus.target_angle = '0;
    bus.angle_update = 1'b0;
    bus.abort_angle  = 1'b0;
    bus.cruise_power = 8'd200;
    bus.enc_angle    = '0;
    bus.enc_valid    = 1'b0;
    bus.pwm_enable   = 1'b1;
    bus.pwm_done     = 1'b0;

    // Reset state
    repeat (3) cyc();
    check("rst_ratio", 32'(bus.pwm_ratio), 0);
    check("rst_update", 32'(bus.pwm_update), 0);
    check("rst_dir", 32'(bus.pwm_direction), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.angle_done), 0);
    check("rst_fail", 32'(bus.startup_fail), 0);
    check("rst_cur", 32'(bus.current_angle), 0);
    reset_n = 1'b1;
    cyc();

    // Basic move 100 -> 600, ramp 24..200
    enc(12'd100);
    check("cur_capture", 32'(bus.current_angle), 100);
    bus.target_angle = 12'd600;
    bus.angle_update = 1'b1;
    exp_r = 24;
    for (int i = 0; i < 120; i++) begin
      cyc();
      if (i == 0) begin
        check("move_dir", 32'(bus.pwm_direction), 1);
        check("move_busy", 32'(bus.busy), 1);
      end
      if (bus.pwm_update) begin
        check("ramp_up", 32'(bus.pwm_ratio), 32'(exp_r));
        if (exp_r == 200) break;
        exp_r += 4;
      end
    end
    check("ramp_top", 32'(bus.pwm_ratio), 200);
    count_updates(3, cnt);
    check("cruise_quiet", 32'(cnt), 0);
    enc(12'd300);
    cyc();
    enc(12'd500);
`ifdef ANGLE_SERVO_SLOWDOWN_EN
    exp_r = 196;
    for (int i = 0; i < 120; i++) begin
      cyc();
      if (bus.pwm_update) begin
        check("ramp_down", 32'(bus.pwm_ratio), 32'(exp_r));
        if (exp_r == 24) break;
        exp_r -= 4;
      end
    end
    check("decel_floor", 32'(bus.pwm_ratio), 24);
`else
    count_updates(5, cnt);
    check("no_slowdown_upd", 32'(cnt), 0);
    check("no_slowdown_ratio", 32'(bus.pwm_ratio), 200);
`endif
    enc(12'd597);
    cyc();
    check("done_update", 32'(bus.pwm_update), 1);
    check("done_ratio", 32'(bus.pwm_ratio), 0);
    check("done_flag", 32'(bus.angle_done), 1);
    check("done_busy", 32'(bus.busy), 0);

    // Wrap-around: 4000 -> 50 goes up, deadband boundary 5/4
    enc(12'd4000);
    cyc();
    request(12'd50);
    check("wrap_up_dir", 32'(bus.pwm_direction), 1);
    check("wrap_up_ratio", 32'(bus.pwm_ratio), 24);
    check("wrap_done_clr", 32'(bus.angle_done), 0);
    enc(12'd45);
    cyc();
    check("db_plus1_busy", 32'(bus.busy), 1);
    enc(12'd46);
    cyc();
    check("db_edge_done", 32'(bus.angle_done), 1);
    check("db_edge_ratio", 32'(bus.pwm_ratio), 0);

    // Wrap-around: 50 -> 4000 goes down; overshoot reverses
    enc(12'd50);
    cyc();
    request(12'd4000);
    check("wrap_dn_dir", 32'(bus.pwm_direction), 0);
    check("wrap_dn_ratio", 32'(bus.pwm_ratio), 24);
    enc(12'd3990);
    cyc();
    check("rev_update", 32'(bus.pwm_update), 1);
    check("rev_dir", 32'(bus.pwm_direction), 1);
    check("rev_ratio", 32'(bus.pwm_ratio), 24);
    abort_now();
    check("abort_ratio", 32'(bus.pwm_ratio), 0);
    check("abort_update", 32'(bus.pwm_update), 1);
    check("abort_busy", 32'(bus.busy), 0);

    // Half-turn tie
    enc(12'd0);
    cyc();
    request(12'd2048);
    check("tie_dir", 32'(bus.pwm_direction), 1);
    abort_now();
    cyc();
    request(12'd2049);
    check("past_half_dir", 32'(bus.pwm_direction), 0);
    abort_now();
    cyc();

    // Abort + update together mid-CRUISE
    enc(12'd100);
    request(12'd600);
    repeat (60) cyc();
    check("cruise_ratio", 32'(bus.pwm_ratio), 200);
    bus.abort_angle  = 1'b1;
    bus.target_angle = 12'd1000;
    bus.angle_update = 1'b1;
    cyc();
    check("abupd_update", 32'(bus.pwm_update), 1);
    check("abupd_ratio", 32'(bus.pwm_ratio), 0);
    check("abupd_busy", 32'(bus.busy), 0);
    count_updates(3, cnt);
    check("abupd_single", 32'(cnt), 0);

    // Withheld pwm_done
    auto_done = 1'b0;
    request(12'd600);
    check("hold_first", 32'(bus.pwm_ratio), 24);
    count_updates(10, cnt);
    check("hold_no_upd", 32'(cnt), 0);
    bus.pwm_done = 1'b1;
    cyc();
    check("hold_step_upd", 32'(bus.pwm_update), 1);
    check("hold_step_ratio", 32'(bus.pwm_ratio), 28);
    count_updates(5, cnt);
    check("hold_no_upd2", 32'(cnt), 0);
    abort_now();
    check("hold_forced_zero", 32'(bus.pwm_update), 1);
    check("hold_forced_ratio", 32'(bus.pwm_ratio), 0);
    bus.pwm_done = 1'b1;
    cyc();
    auto_done = 1'b1;

    // pwm_enable gating
    bus.pwm_enable = 1'b0;
    request(12'd600);
    check("en_off_ignored", 32'(bus.busy), 0);
    check("en_off_no_upd", 32'(bus.pwm_update), 0);
    bus.pwm_enable = 1'b1;
    request(12'd600);
    check("en_on_busy", 32'(bus.busy), 1);
    bus.pwm_enable = 1'b0;
    cyc();
    check("en_drop_busy", 32'(bus.busy), 0);
    check("en_drop_upd", 32'(bus.pwm_update), 1);
    check("en_drop_ratio", 32'(bus.pwm_ratio), 0);
    bus.pwm_enable = 1'b1;
    cyc();

    // Stall fault
    request(12'd600);
    repeat (150) cyc();
    check("stall_early", 32'(bus.startup_fail), 0);
    for (int i = 0; i < 120; i++) begin
      if (bus.startup_fail) break;
      cyc();
    end
    check("stall_fail", 32'(bus.startup_fail), 1);
    check("stall_ratio", 32'(bus.pwm_ratio), 0);
    check("stall_busy", 32'(bus.busy), 0);
    request(12'd900);
    check("fault_ignores_upd", 32'(bus.busy), 0);
    check("fault_sticky", 32'(bus.startup_fail), 1);
    abort_now();
    check("fault_cleared", 32'(bus.startup_fail), 0);

    // Async reset mid-motion
    request(12'd600);
    repeat (5) cyc();
    check("pre_reset_busy", 32'(bus.busy), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_ratio", 32'(bus.pwm_ratio), 0);
    check("async_busy", 32'(bus.busy), 0);
    check("async_update", 32'(bus.pwm_update), 0);
    check("async_cur", 32'(bus.current_angle), 0);
    cyc();
    check("reset_held_upd", 32'(bus.pwm_update), 0);
    reset_n = 1'b1;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
